// File: rtl/banked_dp_ram.sv
// Dual-port word RAM split across NUM_BANKS banks behind one flat address space,
// with range checking, write-collision arbitration and a hardware zeroing sweep.

module bank_ram #(
  parameter int DATA_W = 8,
  parameter int AW     = 16
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic              re_a,
  input  logic [AW-1:0]     addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic [DATA_W-1:0] q_a,
  input  logic              we_b,
  input  logic              re_b,
  input  logic [AW-1:0]     addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic [DATA_W-1:0] q_b
);
  logic [DATA_W-1:0] mem [2**AW];

  // Reads sample the pre-write contents (read-first); port A write lands last.
  always_ff @(posedge clk) begin
    if (re_a) q_a <= mem[addr_a];
    if (re_b) q_b <= mem[addr_b];
    if (we_b) mem[addr_b] <= wdata_b;
    if (we_a) mem[addr_a] <= wdata_a;
  end
endmodule

module banked_dp_ram #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 17,
  parameter int BANK_AW   = 16,
  parameter int NUM_BANKS = 2,
  parameter int DEPTH     = 81920
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  output logic              ready,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic [DATA_W-1:0] rdata_a,
  output logic              rvalid_a,
  output logic              err_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_b,
  output logic              err_b,
  output logic              coll
);
  localparam int BSEL_W = ADDR_W - BANK_AW;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic {INIT, READY} state_t;

  typedef struct packed {
    logic              acc;
    logic              wr;
    logic              rd;
    logic              in_rng;
    logic [BSEL_W-1:0] bidx;
    logic [BANK_AW-1:0] loc;
  } dec_t;

  state_t             state;
  logic [BANK_AW-1:0] cnt;
  logic               init_wr;
  dec_t               dec_a, dec_b;
  logic               coll_now;
  logic [BSEL_W-1:0]  bsel_a, bsel_b;
  logic [NUM_BANKS-1:0][DATA_W-1:0] q_a, q_b;

  assign init_wr = (state == INIT);

  always_comb begin
    dec_a.acc    = en_a & ready;
    dec_a.in_rng = ({1'b0, addr_a} < DEPTH_L);
    dec_a.wr     = dec_a.acc & we_a & dec_a.in_rng;
    dec_a.rd     = dec_a.acc & ~we_a & dec_a.in_rng;
    dec_a.bidx   = addr_a[ADDR_W-1:BANK_AW];
    dec_a.loc    = addr_a[BANK_AW-1:0];
    dec_b.acc    = en_b & ready;
    dec_b.in_rng = ({1'b0, addr_b} < DEPTH_L);
    dec_b.wr     = dec_b.acc & we_b & dec_b.in_rng;
    dec_b.rd     = dec_b.acc & ~we_b & dec_b.in_rng;
    dec_b.bidx   = addr_b[ADDR_W-1:BANK_AW];
    dec_b.loc    = addr_b[BANK_AW-1:0];
  end

  assign coll_now = dec_a.wr & dec_b.wr & (addr_a == addr_b);

  // During INIT port A of every bank is borrowed by the sweep; no requests are live then.
  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    logic hit_a, hit_b;
    assign hit_a = (dec_a.bidx == BSEL_W'(i));
    assign hit_b = (dec_b.bidx == BSEL_W'(i));
    bank_ram #(.DATA_W(DATA_W), .AW(BANK_AW)) u_bank (
      .clk     (clk),
      .we_a    (init_wr | (dec_a.wr & hit_a)),
      .re_a    (dec_a.rd & hit_a),
      .addr_a  (init_wr ? cnt : dec_a.loc),
      .wdata_a (init_wr ? '0 : wdata_a),
      .q_a     (q_a[i]),
      .we_b    (dec_b.wr & hit_b & ~coll_now),
      .re_b    (dec_b.rd & hit_b),
      .addr_b  (dec_b.loc),
      .wdata_b (wdata_b),
      .q_b     (q_b[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == {BANK_AW{1'b1}}) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY: begin
          if (init_req) begin
            state <= INIT;
            ready <= 1'b0;
            cnt   <= '0;
          end
        end
        default: begin
          state <= INIT;
          ready <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Bank select travels with the read so the mux lines up with the registered bank output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      err_a    <= 1'b0;
      err_b    <= 1'b0;
      coll     <= 1'b0;
      bsel_a   <= '0;
      bsel_b   <= '0;
    end else begin
      rvalid_a <= dec_a.acc & ~we_a;
      rvalid_b <= dec_b.acc & ~we_b;
      err_a    <= dec_a.acc & ~dec_a.in_rng;
      err_b    <= dec_b.acc & ~dec_b.in_rng;
      coll     <= coll_now;
      bsel_a   <= dec_a.bidx;
      bsel_b   <= dec_b.bidx;
    end
  end

  // Out-of-range reads (rvalid with err) return zero instead of any bank word.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (rvalid_a && !err_a && bsel_a == BSEL_W'(i)) rdata_a = q_a[i];
      if (rvalid_b && !err_b && bsel_b == BSEL_W'(i)) rdata_b = q_b[i];
    end
  end
endmodule

// File: tb/tb_banked_dp_ram.sv
// Directed bench for banked_dp_ram with 2 banks of 16 words and 20 usable words.

module tb_banked_dp_ram;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int BANK_AW = 4;
  localparam int NUM_BANKS = 2;
  localparam int DEPTH = 20;

  logic clk = 0, rst_n = 0, init_req = 0, ready;
  logic en_a = 0, we_a = 0, en_b = 0, we_b = 0;
  logic [ADDR_W-1:0] addr_a = '0, addr_b = '0;
  logic [DATA_W-1:0] wdata_a = '0, wdata_b = '0, rdata_a, rdata_b;
  logic rvalid_a, rvalid_b, err_a, err_b, coll;
  int total = 0, bad = 0;

  banked_dp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_AW(BANK_AW),
                  .NUM_BANKS(NUM_BANKS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .ready(ready),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .rdata_a(rdata_a), .rvalid_a(rvalid_a), .err_a(err_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_b(rdata_b), .rvalid_b(rvalid_b), .err_b(err_b), .coll(coll)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    en_a = 0; we_a = 0; en_b = 0; we_b = 0; init_req = 0;
  endtask

  task automatic port_a(input logic we, input int addr, input int data);
    en_a = 1; we_a = we; addr_a = ADDR_W'(addr); wdata_a = DATA_W'(data);
  endtask

  task automatic port_b(input logic we, input int addr, input int data);
    en_b = 1; we_b = we; addr_b = ADDR_W'(addr); wdata_b = DATA_W'(data);
  endtask

  // Counts edges until ready rises; bounded so a stuck sweep cannot hang the run.
  task automatic wait_ready(input string name, input int expect_n);
    int n = 0;
    while (!ready && n < 40) begin
      cyc(); n++;
    end
    total++;
    if (n !== expect_n || ready !== 1'b1) begin
      bad++; $display("FAIL %s: cycles=%0d ready=%b, want cycles=%0d ready=1", name, n, ready, expect_n);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({ready, rvalid_a, rvalid_b, err_a, err_b, coll} !== 6'b0 || rdata_a !== 8'h00 || rdata_b !== 8'h00) begin
      bad++; $display("FAIL reset_outputs: ready=%b rv=%b%b err=%b%b coll=%b rd=%h/%h, want all 0",
                      ready, rvalid_a, rvalid_b, err_a, err_b, coll, rdata_a, rdata_b);
    end
    @(negedge clk); rst_n = 1;
    wait_ready("reset_sweep", 16);
    port_a(0, 5, 0); cyc(); idle();
    total++;
    if (rvalid_a !== 1'b1 || rdata_a !== 8'h00 || err_a !== 1'b0) begin
      bad++; $display("FAIL first_read: rvalid=%b rdata=%h err=%b, want 1 00 0", rvalid_a, rdata_a, err_a);
    end
    cyc();
    total++;
    if (rvalid_a !== 1'b0) begin
      bad++; $display("FAIL rvalid_pulse: rvalid=%b, want 0", rvalid_a);
    end
  endtask

  task automatic test_bank_boundary();
    port_a(1, 15, 'hA5); port_b(1, 16, 'h5A); cyc(); idle();
    total++;
    if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0 || coll !== 1'b0) begin
      bad++; $display("FAIL write_no_rvalid: rvalid=%b%b coll=%b, want 00 0", rvalid_a, rvalid_b, coll);
    end
    port_a(0, 16, 0); port_b(0, 15, 0); cyc(); idle();
    total++;
    if (rvalid_a !== 1'b1 || rvalid_b !== 1'b1 || rdata_a !== 8'h5A || rdata_b !== 8'hA5) begin
      bad++; $display("FAIL boundary_read: rv=%b%b rd=%h/%h, want 11 5a/a5", rvalid_a, rvalid_b, rdata_a, rdata_b);
    end
  endtask

  task automatic test_out_of_range();
    // 36 decodes to nonexistent bank 2, local 4; 20 is the first address past DEPTH.
    port_a(1, 36, 'hFF); port_b(1, 20, 'hEE); cyc(); idle();
    total++;
    if (err_a !== 1'b1 || err_b !== 1'b1 || rvalid_a !== 1'b0) begin
      bad++; $display("FAIL oor_write: err=%b%b rvalid_a=%b, want 11 0", err_a, err_b, rvalid_a);
    end
    port_a(0, 36, 0); port_b(0, 4, 0); cyc(); idle();
    total++;
    if (rvalid_a !== 1'b1 || rdata_a !== 8'h00 || err_a !== 1'b1) begin
      bad++; $display("FAIL oor_read: rvalid=%b rdata=%h err=%b, want 1 00 1", rvalid_a, rdata_a, err_a);
    end
    total++;
    if (rvalid_b !== 1'b1 || rdata_b !== 8'h00 || err_b !== 1'b0) begin
      bad++; $display("FAIL oor_no_alias: rvalid=%b rdata=%h err=%b, want 1 00 0", rvalid_b, rdata_b, err_b);
    end
    cyc();
    total++;
    if (err_a !== 1'b0 || err_b !== 1'b0) begin
      bad++; $display("FAIL err_pulse: err=%b%b, want 00", err_a, err_b);
    end
  endtask

  task automatic test_collision();
    port_a(1, 4, 'h11); port_b(1, 4, 'h22); cyc(); idle();
    total++;
    if (coll !== 1'b1) begin
      bad++; $display("FAIL coll_set: coll=%b, want 1", coll);
    end
    port_a(0, 4, 0); port_b(0, 4, 0); cyc(); idle();
    total++;
    if (coll !== 1'b0 || rdata_a !== 8'h11 || rdata_b !== 8'h11) begin
      bad++; $display("FAIL coll_winner: coll=%b rd=%h/%h, want 0 11/11", coll, rdata_a, rdata_b);
    end
  endtask

  task automatic test_read_first();
    port_a(1, 17, 'h33); cyc(); idle();
    port_a(0, 17, 0); port_b(1, 17, 'h44); cyc(); idle();
    total++;
    if (rvalid_a !== 1'b1 || rdata_a !== 8'h33) begin
      bad++; $display("FAIL read_first_old: rvalid=%b rdata=%h, want 1 33", rvalid_a, rdata_a);
    end
    port_a(0, 17, 0); cyc(); idle();
    total++;
    if (rdata_a !== 8'h44) begin
      bad++; $display("FAIL read_first_new: rdata=%h, want 44", rdata_a);
    end
  endtask

  task automatic test_back_to_back();
    int adr[4] = '{15, 16, 17, 4};
    logic [7:0] exp_d[4] = '{8'hA5, 8'h5A, 8'h44, 8'h11};
    for (int i = 0; i < 4; i++) begin
      port_a(0, adr[i], 0); port_b(0, adr[3-i], 0); cyc();
      total++;
      if (rvalid_a !== 1'b1 || rvalid_b !== 1'b1 || rdata_a !== exp_d[i] || rdata_b !== exp_d[3-i]) begin
        bad++; $display("FAIL b2b[%0d]: rv=%b%b rd=%h/%h, want 11 %h/%h", i, rvalid_a, rvalid_b,
                        rdata_a, rdata_b, exp_d[i], exp_d[3-i]);
      end
    end
    idle();
  endtask

  task automatic test_init_req();
    init_req = 1; port_a(0, 16, 0); cyc(); idle();
    total++;
    if (ready !== 1'b0 || rvalid_a !== 1'b1 || rdata_a !== 8'h5A) begin
      bad++; $display("FAIL init_edge: ready=%b rvalid=%b rdata=%h, want 0 1 5a", ready, rvalid_a, rdata_a);
    end
    // Requests and a second init_req during the sweep must have no effect.
    port_a(0, 36, 0); port_b(0, 4, 0); init_req = 1; cyc(); idle();
    total++;
    if (rvalid_a !== 1'b0 || err_a !== 1'b0 || rvalid_b !== 1'b0) begin
      bad++; $display("FAIL init_ignore: rvalid=%b%b err_a=%b, want 00 0", rvalid_a, rvalid_b, err_a);
    end
    wait_ready("init_sweep", 15);
    port_a(0, 15, 0); port_b(0, 4, 0); cyc(); idle();
    total++;
    if (rdata_a !== 8'h00 || rdata_b !== 8'h00 || rvalid_a !== 1'b1) begin
      bad++; $display("FAIL init_cleared: rd=%h/%h rvalid=%b, want 00/00 1", rdata_a, rdata_b, rvalid_a);
    end
  endtask

  task automatic test_reset_mid_sweep();
    port_a(1, 15, 'hA5); port_b(1, 16, 'h5A); cyc(); idle();
    init_req = 1; cyc(); idle();
    repeat (8) cyc();
    port_a(0, 36, 0);
    rst_n = 0; #1;
    total++;
    if (ready !== 1'b0 || rvalid_a !== 1'b0 || err_a !== 1'b0 || coll !== 1'b0) begin
      bad++; $display("FAIL mid_reset: ready=%b rvalid=%b err=%b coll=%b, want 0 0 0 0", ready, rvalid_a, err_a, coll);
    end
    idle();
    @(negedge clk); rst_n = 1;
    wait_ready("resweep", 16);
    port_a(0, 15, 0); port_b(0, 16, 0); cyc(); idle();
    total++;
    if (rdata_a !== 8'h00 || rdata_b !== 8'h00 || rvalid_b !== 1'b1) begin
      bad++; $display("FAIL resweep_cleared: rd=%h/%h rvalid_b=%b, want 00/00 1", rdata_a, rdata_b, rvalid_b);
    end
  endtask

  initial begin
    test_reset();
    test_bank_boundary();
    test_out_of_range();
    test_collision();
    test_read_first();
    test_back_to_back();
    test_init_req();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/banked_dp_ram.md
# banked_dp_ram

Parametrised true dual-port byte/word RAM built from NUM_BANKS equal banks behind a flat address space of DEPTH words, the general successor of the team's fixed two-bank memory wrapper. It adds registered bank select aligned with the read latency, range checking, write-collision arbitration, read-valid handshaking and a hardware zero-initialisation sequencer. It sits between the datapath engines and on-chip storage as the shared working memory.

## Interface
- DATA_W, 8, data word width in bits
- ADDR_W, 17, flat address width
- BANK_AW, 16, per-bank address width; each bank holds 2^BANK_AW words
- NUM_BANKS, 2, number of banks; NUM_BANKS*2^BANK_AW >= DEPTH required
- DEPTH, 81920, usable words; addresses >= DEPTH are out of range
- clk  in  1  sole clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- init_req  in  1  one-cycle pulse: re-run zero initialisation
- ready  out  1  1 = init complete, ports accept requests
- en_a, en_b  in  1  request strobe per port
- we_a, we_b  in  1  1 = write, 0 = read (qualified by en)
- addr_a, addr_b  in  ADDR_W  flat word address
- wdata_a, wdata_b  in  DATA_W  write data
- rdata_a, rdata_b  out  DATA_W  read data
- rvalid_a, rvalid_b  out  1  rdata valid this cycle
- err_a, err_b  out  1  previous-cycle request was out of range
- coll  out  1  previous-cycle dual write to same address

## Operation
- Bank index = addr >> BANK_AW; local address = addr[BANK_AW-1:0]; per-port decode is independent, so both ports may hit the same or different banks.
- Request accepted when en=1 and ready=1; requests with ready=0 are ignored entirely (no write, no rvalid, no err).
- In-range write: selected bank written at local address; all other banks untouched.
- In-range read: rvalid=1 and rdata=bank word one cycle after acceptance; bank index is registered alongside so output mux matches the registered bank output.
- Out-of-range (addr >= DEPTH): write dropped; read returns rdata=0 with rvalid=1; err=1 for one cycle either way.
- Both ports write same in-range address same cycle: port A data stored, port B dropped, coll=1 next cycle.
- One port reads, other writes same address same cycle: read-first, reader gets old data.
- Writes produce no rvalid.
- Init FSM states: INIT, READY.
  - INIT: counter sweeps 0..2^BANK_AW-1, writing 0 to that local address in all banks in parallel; ready=0.
  - INIT -> READY when counter reaches 2^BANK_AW-1 (that write included).
  - READY -> INIT on init_req=1; counter restarts at 0.
  - init_req during INIT: ignored.
- Memory contents are not reset; they are cleared only by the INIT sweep.

## Timing
- Reset values: ready=0, rdata_a/b=0, rvalid_a/b=0, err_a/b=0, coll=0, FSM=INIT, counter=0.
- rst_n assertion mid-sweep or mid-access: outputs return to reset values immediately; after release the sweep restarts at 0.
- After rst_n release, ready rises after exactly 2^BANK_AW clock edges; first request accepted on the cycle ready=1 is seen.
- init_req at edge N: ready=0 from edge N+1; a read accepted at edge N still returns rvalid at N+1.
- Read latency 1 cycle, fully pipelined: back-to-back reads on both ports every cycle, no stalls.
- rvalid, err, coll are single-cycle pulses per request.
- Reads with an out-of-range address never drive rdata from a bank.

## Test plan
- Reset release with BANK_AW=4, NUM_BANKS=2, DEPTH=20 -> ready=0 for 16 cycles then 1; read addr 5 -> rvalid=1, rdata=0x00 next cycle.
- Defaults: write A addr 0x0FFFF=0xA5, B addr 0x10000=0x5A; next cycle read A 0x10000, B 0x0FFFF -> rdata_a=0x5A, rdata_b=0xA5 with rvalid one cycle later.
- Write A addr 0x14000=0xFF -> err_a=1, no bank change; read A 0x14000 -> rvalid_a=1, rdata_a=0x00, err_a=1.
- Both ports write 0x00100, A=0x11, B=0x22 -> coll=1 one cycle; read 0x00100 -> 0x11.
- mem[0x10010]=0x33; A reads and B writes 0x44 there same cycle -> rdata_a=0x33; next read -> 0x44.
- After writing 0x0FFFF=0xA5, pulse init_req -> ready=0 next cycle, 65536 cycles later ready=1, read 0x0FFFF -> 0x00; repeat with rst_n pulsed mid-sweep -> sweep restarts, same final result.
